// File: rtl/lc3_ctrl_pkg.sv
// Shared types and constants for the LC-3 run controller.
// Mode encoding matches the externally visible mode port.
package lc3_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    USTEP  = 2'd2,
    ISTEP  = 2'd3
  } mode_e;

  localparam logic [5:0] FETCH_STATE_DEFAULT = 6'd18;

  localparam int KEY_USTEP = 0;
  localparam int KEY_ISTEP = 1;
  localparam int KEY_RUN   = 2;

endpackage

// File: rtl/key_debounce.sv
// Synchronised, debounced active-low key with a one-cycle press pulse.
// Both press and release must hold for DEBOUNCE_CYCLES cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = (r_s2 != r_stable);
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1    <= key_n;
      r_s2    <= r_s1;
      r_press <= w_accept && !r_s2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press_pulse = r_press;

endmodule

// File: rtl/lc3_run_controller.sv
// Clock-enable sequencer for the LC-3: pause, run, micro-step and
// instruction-step, with a PC breakpoint and a step timeout.
module lc3_run_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int         TICK_DIV        = 50000000,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [5:0] FETCH_STATE     = FETCH_STATE_DEFAULT,
  parameter int         STEP_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key_n,
  input  logic [5:0]  current_state,
  input  logic [15:0] pc,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic        bp_hit,
  output logic        step_timeout,
  output logic [15:0] ce_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEP_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_TIMEOUT);

  logic [2:0]    w_press;
  logic          w_tog;
  logic          w_ist;
  logic          w_ust;
  logic          w_bp_match;
  logic          w_fetch;

  mode_e         r_mode;
  logic          r_ce;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_step;
  logic          r_bp_hit;
  logic          r_to;
  logic          r_resume;
  logic [15:0]   r_ce_count;

  mode_e         w_mode_n;
  logic          w_ce_n;
  logic [PW-1:0] w_presc_n;
  logic [SW-1:0] w_step_n;
  logic          w_bp_n;
  logic          w_to_n;
  logic          w_resume_n;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[gi]),
      .press_pulse(w_press[gi])
    );
  end

  assign w_tog = w_press[KEY_RUN];
  assign w_ist = w_press[KEY_ISTEP] && !w_tog;
  assign w_ust = w_press[KEY_USTEP] && !w_tog
              && !w_press[KEY_ISTEP];

  assign w_fetch    = (current_state == FETCH_STATE);
  assign w_bp_match = bp_en && w_fetch && (pc == bp_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= PAUSED;
      r_ce       <= 1'b0;
      r_presc    <= '0;
      r_step     <= '0;
      r_bp_hit   <= 1'b0;
      r_to       <= 1'b0;
      r_resume   <= 1'b0;
      r_ce_count <= '0;
    end else begin
      r_mode   <= w_mode_n;
      r_ce     <= w_ce_n;
      r_presc  <= w_presc_n;
      r_step   <= w_step_n;
      r_bp_hit <= w_bp_n;
      r_to     <= w_to_n;
      r_resume <= w_resume_n;
      if (r_ce) r_ce_count <= r_ce_count + 16'd1;
    end
  end

  always_comb begin
    w_mode_n   = r_mode;
    w_ce_n     = 1'b0;
    w_presc_n  = r_presc;
    w_step_n   = r_step;
    w_bp_n     = r_bp_hit;
    w_to_n     = r_to;
    w_resume_n = r_resume;
    unique case (r_mode)
      PAUSED: begin
        if (w_tog) begin
          w_mode_n   = RUN;
          w_bp_n     = 1'b0;
          w_to_n     = 1'b0;
          w_presc_n  = '0;
          w_resume_n = 1'b1;
        end else if (w_ist) begin
          w_mode_n = ISTEP;
          w_to_n   = 1'b0;
          w_step_n = '0;
        end else if (w_ust) begin
          w_mode_n = USTEP;
        end
      end
      RUN: begin
        // Breakpoint stays masked until the first ce after resuming.
        if (r_ce) w_resume_n = 1'b0;
        if (w_tog) begin
          w_mode_n = PAUSED;
        end else if (w_bp_match && !r_ce && !r_resume) begin
          w_mode_n = PAUSED;
          w_bp_n   = 1'b1;
        end else if (r_presc == PRESC_MAX) begin
          w_ce_n    = 1'b1;
          w_presc_n = '0;
        end else begin
          w_presc_n = r_presc + 1'b1;
        end
      end
      USTEP: begin
        w_ce_n   = 1'b1;
        w_mode_n = PAUSED;
      end
      ISTEP: begin
        if (w_tog) begin
          w_mode_n = PAUSED;
        end else if (r_ce) begin
          w_ce_n = 1'b0;
        end else if (r_step != '0 && w_fetch) begin
          w_mode_n = PAUSED;
        end else if (r_step == STEP_MAX) begin
          w_mode_n = PAUSED;
          w_to_n   = 1'b1;
        end else begin
          w_ce_n   = 1'b1;
          w_step_n = r_step + 1'b1;
        end
      end
    endcase
  end

  assign cpu_ce       = r_ce;
  assign mode         = r_mode;
  assign bp_hit       = r_bp_hit;
  assign step_timeout = r_to;
  assign ce_count     = r_ce_count;

endmodule

// File: tb/tb_lc3_run_controller.sv
// Directed bench for lc3_run_controller with a tiny microsequencer model
// and a queue of expected results.
module tb_lc3_run_controller;
  import lc3_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  key_n;
  logic [5:0]  m_state;
  logic [15:0] m_pc;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic        bp_hit;
  logic        step_timeout;
  logic [15:0] ce_count;

  logic        m_ld;
  logic        m_stuck;
  logic [15:0] m_ld_pc;

  int tests = 0;
  int fails = 0;
  int sb_q[$];

  lc3_run_controller #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .FETCH_STATE    (6'd18),
    .STEP_TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .current_state(m_state),
    .pc           (m_pc),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .cpu_ce       (cpu_ce),
    .mode         (mode),
    .bp_hit       (bp_hit),
    .step_timeout (step_timeout),
    .ce_count     (ce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 18 -> 33 -> 35 -> 18 per instruction; stuck parks in 32 forever.
  always @(posedge clk) begin
    if (m_ld) begin
      m_state <= 6'd18;
      m_pc    <= m_ld_pc;
    end else if (cpu_ce) begin
      if (m_state == 6'd18) begin
        m_state <= 6'd33;
        m_pc    <= m_pc + 16'd1;
      end else if (m_state == 6'd33) begin
        m_state <= 6'd35;
      end else if (m_state == 6'd35) begin
        m_state <= m_stuck ? 6'd32 : 6'd18;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic load(input logic [15:0] p, input logic stuck);
    @(negedge clk);
    m_ld_pc = p;
    m_stuck = stuck;
    m_ld    = 1'b1;
    @(negedge clk);
    m_ld    = 1'b0;
  endtask

  task automatic watch(input logic [2:0] keys, input int hold,
                       input int ncyc, output int pulses,
                       output int mingap, output int maxgap,
                       output int t_entry, output int t_ce,
                       output logic [3:0] seen);
    logic [1:0] m0;
    int last;
    pulses  = 0;
    mingap  = 1000;
    maxgap  = 0;
    t_entry = -1;
    t_ce    = -1;
    seen    = '0;
    last    = -1;
    m0      = mode;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      seen[mode] = 1'b1;
      if (t_entry < 0 && mode != m0) t_entry = i;
      if (cpu_ce) begin
        if (t_ce < 0) t_ce = i;
        if (last >= 0) begin
          if (i - last < mingap) mingap = i - last;
          if (i - last > maxgap) maxgap = i - last;
        end
        last = i;
        pulses++;
      end
      key_n = (i < hold) ? ~keys : 3'b111;
    end
  endtask

  initial begin
    int np, mn, mx, te, tc;
    logic [3:0] sn;
    logic found;
    rst     = 1'b1;
    key_n   = 3'b111;
    bp_en   = 1'b0;
    bp_addr = 16'h0000;
    m_ld    = 1'b1;
    m_ld_pc = 16'h3000;
    m_stuck = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mode", mode, 0);
    check("reset_ce", cpu_ce, 0);
    rst  = 1'b0;
    m_ld = 1'b0;

    watch(3'b000, 0, 100, np, mn, mx, te, tc, sn);
    check("idle_pulses", np, 0);
    check("idle_mode", mode, 0);
    check("idle_ce_count", ce_count, 0);

    watch(3'b100, 2, 20, np, mn, mx, te, tc, sn);
    check("bounce_no_run", sn[1], 0);
    check("bounce_mode", mode, 0);

    watch(3'b100, 10, 30, np, mn, mx, te, tc, sn);
    check("run_entered", mode, 1);
    sb_q.push_back(32'(ce_count) + 5);
    watch(3'b000, 0, 20, np, mn, mx, te, tc, sn);
    check("run_pulses20", np, 5);
    check("run_mingap", mn, 4);
    check("run_maxgap", mx, 4);
    pop_check("run_ce_count", 32'(ce_count));

    watch(3'b100, 10, 40, np, mn, mx, te, tc, sn);
    check("pause_mode", mode, 0);
    watch(3'b000, 0, 20, np, mn, mx, te, tc, sn);
    check("pause_no_ce", np, 0);

    sb_q.push_back(32'(ce_count) + 1);
    watch(3'b001, 10, 30, np, mn, mx, te, tc, sn);
    check("ustep_pulses", np, 1);
    check("ustep_seen", sn[2], 1);
    check("ustep_latency", tc - te, 1);
    check("ustep_back_paused", mode, 0);
    pop_check("ustep_ce_count", 32'(ce_count));

    load(16'h3000, 1'b0);
    sb_q.push_back(3);
    watch(3'b010, 10, 60, np, mn, mx, te, tc, sn);
    pop_check("istep_pulses", np);
    check("istep_entry_ce", tc - te, 1);
    check("istep_mingap", mn, 2);
    check("istep_maxgap", mx, 2);
    check("istep_mode", mode, 0);
    check("istep_no_timeout", step_timeout, 0);
    check("istep_at_fetch", m_state, 18);

    load(16'h3000, 1'b1);
    sb_q.push_back(8);
    watch(3'b010, 10, 60, np, mn, mx, te, tc, sn);
    pop_check("timeout_pulses", np);
    check("timeout_flag", step_timeout, 1);
    check("timeout_mode", mode, 0);

    load(16'h3000, 1'b0);
    bp_en   = 1'b1;
    bp_addr = 16'h3003;
    sb_q.push_back(9);
    watch(3'b100, 10, 200, np, mn, mx, te, tc, sn);
    pop_check("bp_pulses", np);
    check("bp_mode", mode, 0);
    check("bp_hit", bp_hit, 1);
    check("bp_pc", m_pc, 16'h3003);
    check("bp_state", m_state, 18);
    check("bp_timeout_cleared", step_timeout, 0);

    watch(3'b100, 10, 60, np, mn, mx, te, tc, sn);
    check("resume_mode", mode, 1);
    check("resume_bp_clear", bp_hit, 0);
    check("resume_pc_past", m_pc > 16'h3003, 1);
    watch(3'b100, 10, 40, np, mn, mx, te, tc, sn);
    check("resume_paused", mode, 0);
    bp_en = 1'b0;

    load(16'h3000, 1'b0);
    watch(3'b101, 10, 30, np, mn, mx, te, tc, sn);
    check("coinc_no_ustep", sn[2], 0);
    check("coinc_run", mode, 1);
    check("coinc_first_ce", tc - te, 4);
    watch(3'b100, 10, 40, np, mn, mx, te, tc, sn);
    check("coinc_paused", mode, 0);

    load(16'h3000, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      key_n = 3'b101;
      if (cpu_ce && mode == 2'd3) found = 1'b1;
    end
    check("rst_mid_istep_found", found, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ce", cpu_ce, 0);
    check("rst_async_mode", mode, 0);
    check("rst_async_count", ce_count, 0);
    key_n = 3'b111;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    watch(3'b000, 0, 30, np, mn, mx, te, tc, sn);
    check("rst_no_more_ce", np, 0);
    check("rst_stays_paused", mode, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
